interval_countdown_timer: RTL and testbench
===========================================

// Module: interval_countdown_timer
// PURPOSE
//  Countdown timer that consumes the programmable 4-bit time parameters of the anti-theft system.
//  The main anti-theft FSM requests an interval (ARM, DRIVER, PASSENGER, ALARM_ON).
//  This block drives `interval` to the time-parameter stage and loads the returned `value` in seconds.
//  It counts down on an internal 1 Hz tick, then raises a one-cycle `expired` to the FSM.
// PARAMETERS
//  CLK_FREQ  50_000_000  clock cycles per second (1 Hz tick divisor); must be >= 2
//  WIDTH     4           width of time value / remaining count (matches parameter stage)
// PORTS
//  clock        in   1      system clock, all state on rising edge
//  systemReset  in   1      asynchronous, active-high reset
//  startTimer   in   1      1-cycle request: start/restart countdown of intervalSel
//  abortTimer   in   1      1-cycle request: cancel countdown, no expiry
//  intervalSel  in   2      00 ARM, 01 DRIVER, 10 PASSENGER, 11 ALARM_ON
//  value        in   WIDTH  seconds, from time-parameter stage (combinational fn of interval)
//  interval     out  2      registered selector driven to time-parameter stage
//  remaining    out  WIDTH  seconds left in current countdown
//  busy         out  1      1 whenever state != IDLE
//  expired      out  1      1 for exactly one cycle when countdown reaches 0
// BEHAVIOUR
//  Reset (async): state=IDLE, interval=2'b00, remaining=0, busy=0, expired=0, prescaler=0.
//  FSM states: IDLE, LOAD, COUNT, EXPIRE. `busy` and `expired` are Moore decodes of state.
//  - IDLE: startTimer -> interval<=intervalSel, go LOAD.
//  - LOAD (1 cycle): remaining<=value; prescaler synchronously cleared.
//      value==0 -> EXPIRE; else -> COUNT.
//  - COUNT: on tick, remaining<=remaining-1; tick with remaining==1 -> EXPIRE.
//      remaining never wraps below 0.
//  - EXPIRE (1 cycle): expired=1, then IDLE. remaining stays 0.
//  Restart: startTimer in LOAD/COUNT/EXPIRE -> interval<=intervalSel, go LOAD.
//      Old countdown is discarded.
//      A restart in EXPIRE does not suppress that cycle's expired pulse.
//  Abort: abortTimer in any state -> IDLE next cycle, remaining<=0.
//      No expired pulse except one already in EXPIRE that cycle.
//      abortTimer and startTimer in the same cycle: abort wins.
//  `value` is sampled only in LOAD.
//      Reprogramming the parameter stage mid-count does not affect the running countdown.
//  Latency, start in cycle t, value V, N=CLK_FREQ:
//      LOAD at t+1; expired high in cycle t+2+V*N.
//      V==0: expired at t+2.
//  Tick: prescaler counts 0..N-1, runs continuously, tick when count==N-1.
//      Cleared in LOAD so the first second is a full N cycles.
//  Reset mid-operation: immediate return to reset values, no expired pulse.
// STRUCTURE
//  Shared package anti_theft_pkg:
//      interval codes (INT_ARM=2'b00, INT_DRIVER=2'b01, INT_PASSENGER=2'b10, INT_ALARM_ON=2'b11)
//      timer state encoding (IDLE, LOAD, COUNT, EXPIRE)
//  Sub-module one_hz_prescaler #(CLK_FREQ): ports clock, systemReset, clear, tick.
//      Counter width $clog2(CLK_FREQ).
//  Top: FSM, interval register, remaining down-counter.
// TESTING (bench uses CLK_FREQ=4, parameter stage defaults ARM=6, DRIVER=8, PASSENGER=15, ALARM=10)
//  1. start, intervalSel=00 (V=6) in cycle t -> interval=00 at t+1, remaining=6 at t+2;
//     expired single pulse at t+26; busy falls at t+27.
//  2. Reprogram DRIVER to 0, start intervalSel=01 at t -> expired at t+2, remaining=0, no COUNT cycles.
//  3. Start ALARM (V=10), at remaining=5 start PASSENGER ->
//     interval=10, remaining reloads to 15, expired exactly 62 cycles after restart.
//  4. Start ARM, abortTimer at remaining=3 -> IDLE next cycle, remaining=0, expired never asserts.
//  5. startTimer and abortTimer in same cycle from IDLE and from COUNT -> IDLE, busy=0, no expired.
//  6. systemReset asserted mid-COUNT (async, between edges) ->
//     outputs at reset values immediately; after release, new start times correctly as in case 1.

Source files
------------

// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft system: interval selector codes and
// the countdown timer's state encoding.
package anti_theft_pkg;

    localparam int unsigned INTERVAL_W = 2;

    // Interval selector codes driven to the time-parameter stage
    localparam logic [INTERVAL_W-1:0] INT_ARM       = 2'b00;
    localparam logic [INTERVAL_W-1:0] INT_DRIVER    = 2'b01;
    localparam logic [INTERVAL_W-1:0] INT_PASSENGER = 2'b10;
    localparam logic [INTERVAL_W-1:0] INT_ALARM_ON  = 2'b11;

    // Countdown timer FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_COUNT  = 2'b10,
        ST_EXPIRE = 2'b11
    } timer_state_e;

endpackage

// File: rtl/interval_countdown_timer_if.sv
// Request/status bundle between the anti-theft FSM (master), the time-parameter
// stage (which supplies value) and the interval countdown timer (slave).
//   startTimer/abortTimer : one-cycle requests
//   intervalSel           : interval to time on start
//   value                 : seconds for the currently driven interval
//   interval              : registered selector back to the parameter stage
//   remaining/busy/expired: countdown status
interface interval_countdown_timer_if #(
    parameter int unsigned WIDTH = 4
);
    import anti_theft_pkg::*;

    logic                  startTimer;
    logic                  abortTimer;
    logic [INTERVAL_W-1:0] intervalSel;
    logic [WIDTH-1:0]      value;
    logic [INTERVAL_W-1:0] interval;
    logic [WIDTH-1:0]      remaining;
    logic                  busy;
    logic                  expired;

    modport master (
        output startTimer, abortTimer, intervalSel, value,
        input  interval, remaining, busy, expired
    );

    modport slave (
        input  startTimer, abortTimer, intervalSel, value,
        output interval, remaining, busy, expired
    );

endinterface

// File: rtl/one_hz_prescaler.sv
// Free-running divide-by-CLK_FREQ counter producing a one-cycle tick per second.
//   clock, systemReset : clock and asynchronous active-high reset
//   clear              : synchronous restart of the count at 0
//   tick               : high while the count sits at CLK_FREQ-1
module one_hz_prescaler #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic clock,
    input  logic systemReset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wrap explicitly at LAST so non-power-of-two divisors work
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge systemReset) begin
        if (systemReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/interval_countdown_timer.sv
// Countdown timer for the anti-theft intervals. Latches the requested interval,
// loads its length in seconds from the parameter stage and counts down on a
// 1 Hz tick, pulsing expired for one cycle at zero.
//   clock, systemReset : clock and asynchronous active-high reset
//   tmr (slave)        : start/abort requests, interval select, value in;
//                        interval, remaining, busy, expired out
module interval_countdown_timer
    import anti_theft_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned WIDTH    = 4
) (
    input logic                       clock,
    input logic                       systemReset,
    interval_countdown_timer_if.slave tmr
);

    timer_state_e          state_q, state_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;
    logic [WIDTH-1:0]      remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  expired_q, expired_d;
    logic                  tick;
    logic                  prescaler_clear_c;

    // LOAD restarts the second so the first count period is a full second
    assign prescaler_clear_c = (state_q == ST_LOAD);

    one_hz_prescaler #(
        .CLK_FREQ (CLK_FREQ)
    ) u_prescaler (
        .clock       (clock),
        .systemReset (systemReset),
        .clear       (prescaler_clear_c),
        .tick        (tick)
    );

    // Next-state, interval and remaining-count logic
    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tmr.startTimer) begin
                    interval_d = tmr.intervalSel;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                remaining_d = tmr.value;
                state_d     = (tmr.value == '0) ? ST_EXPIRE : ST_COUNT;
            end
            ST_COUNT: begin
                if (tick) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - WIDTH'(1);
                    end
                    if (remaining_q <= WIDTH'(1)) begin
                        state_d = ST_EXPIRE;
                    end
                end
            end
            ST_EXPIRE: begin
                remaining_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart from any active state discards the running countdown
        if (tmr.startTimer && (state_q != ST_IDLE)) begin
            interval_d = tmr.intervalSel;
            state_d    = ST_LOAD;
        end

        // Abort dominates a simultaneous start
        if (tmr.abortTimer) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end

        // Status flops track the next state so they align with the state register
        busy_d    = (state_d != ST_IDLE);
        expired_d = (state_d == ST_EXPIRE);
    end

    always_ff @(posedge clock or posedge systemReset) begin
        if (systemReset) begin
            state_q     <= ST_IDLE;
            interval_q  <= INT_ARM;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    assign tmr.interval  = interval_q;
    assign tmr.remaining = remaining_q;
    assign tmr.busy      = busy_q;
    assign tmr.expired   = expired_q;

endmodule

// File: tb/tb_interval_countdown_timer.sv
// Bench for interval_countdown_timer: directed scenarios plus random start/abort
// traffic, checked against a deadline-based reference model and an expiry scoreboard.
module tb_interval_countdown_timer;
    import anti_theft_pkg::*;

    localparam int unsigned CLK_FREQ = 4;
    localparam int unsigned WIDTH    = 4;

    logic clock = 1'b0;
    logic systemReset;
    always #5 clock = ~clock;

    interval_countdown_timer_if #(.WIDTH(WIDTH)) tif();

    // Time-parameter stage: combinational lookup on the registered interval
    logic [WIDTH-1:0] params [4];
    assign tif.value = params[tif.interval];

    interval_countdown_timer #(
        .CLK_FREQ (CLK_FREQ),
        .WIDTH    (WIDTH)
    ) dut (
        .clock       (clock),
        .systemReset (systemReset),
        .tmr         (tif.slave)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    typedef struct {
        int         dl;
        logic [1:0] sel;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a countdown started in cycle t0 with V seconds expires at
    // t0 + 2 + V*CLK_FREQ; remaining drops by one every CLK_FREQ cycles from t0+2.
    bit         act = 0;
    int         t0, v, dl;
    logic [1:0] msel;

    always @(negedge clock) begin
        int c;
        exp_t e;
        c = cyc;
        if (systemReset) begin
            chk("rst_busy", int'(tif.busy), 0);
            chk("rst_remaining", int'(tif.remaining), 0);
            chk("rst_interval", int'(tif.interval), 0);
            chk("rst_expired", int'(tif.expired), 0);
            act = 0;
            exp_q.delete();
        end else begin
            if (act) begin
                chk("busy", int'(tif.busy), 1);
                chk("interval", int'(tif.interval), int'(msel));
                if (c >= t0 + 2)
                    chk("remaining", int'(tif.remaining), v - (c - t0 - 2) / int'(CLK_FREQ));
            end else begin
                chk("idle_busy", int'(tif.busy), 0);
                chk("idle_remaining", int'(tif.remaining), 0);
            end
            // Value is taken in the cycle after the start
            if (act && c == t0 + 1) begin
                v    = int'(params[msel]);
                dl   = t0 + 2 + v * int'(CLK_FREQ);
                e.dl = dl;
                e.sel = msel;
                exp_q.push_back(e);
            end
            if (act && c >= t0 + 2 && c == dl) act = 0;
            if (tif.abortTimer || tif.startTimer) begin
                if (exp_q.size() > 0 && exp_q[$].dl > c) void'(exp_q.pop_back());
                if (tif.abortTimer) begin
                    act = 0;
                end else begin
                    act  = 1;
                    t0   = c;
                    msel = tif.intervalSel;
                end
            end
        end
    end

    // Expiry monitor: every pulse must match the oldest pending deadline
    always @(negedge clock) begin
        if (!systemReset) begin
            if (exp_q.size() > 0 && exp_q[0].dl == cyc) begin
                chk("expired_pulse", int'(tif.expired), 1);
                chk("expired_interval", int'(tif.interval), int'(exp_q[0].sel));
                void'(exp_q.pop_front());
            end else begin
                chk("expired_quiet", int'(tif.expired), 0);
            end
        end
    end

    task automatic drive(input logic s, input logic a, input logic [1:0] sel);
        @(posedge clock);
        #1;
        tif.startTimer  = s;
        tif.abortTimer  = a;
        tif.intervalSel = sel;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00);
    endtask

    task automatic wait_remaining(input int target, input string name);
        for (int i = 0; i < 100 && int'(tif.remaining) != target; i++) idle(1);
        chk(name, int'(tif.remaining), target);
    endtask

    initial begin
        int r;
        logic s, a;
        systemReset     = 1'b1;
        tif.startTimer  = 1'b0;
        tif.abortTimer  = 1'b0;
        tif.intervalSel = INT_ARM;
        params = '{4'd6, 4'd8, 4'd15, 4'd10};
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", int'(tif.busy), 0);
        chk("reset_remaining", int'(tif.remaining), 0);
        systemReset = 1'b0;
        idle(2);

        // 1: ARM, 6 s; parameter stage reprogrammed mid-count has no effect
        drive(1'b1, 1'b0, INT_ARM);
        idle(6);
        params[0] = 4'd2;
        idle(25);
        params[0] = 4'd6;

        // 2: zero-length DRIVER interval expires straight from LOAD
        params[1] = 4'd0;
        drive(1'b1, 1'b0, INT_DRIVER);
        idle(5);
        params[1] = 4'd8;

        // 3: ALARM restarted as PASSENGER at remaining 5
        drive(1'b1, 1'b0, INT_ALARM_ON);
        wait_remaining(5, "reach_rem5");
        drive(1'b1, 1'b0, INT_PASSENGER);
        idle(70);

        // 4: abort at remaining 3
        drive(1'b1, 1'b0, INT_ARM);
        wait_remaining(3, "reach_rem3");
        drive(1'b0, 1'b1, INT_ARM);
        idle(30);

        // 5: simultaneous start and abort from IDLE and from COUNT
        drive(1'b1, 1'b1, INT_PASSENGER);
        idle(3);
        drive(1'b1, 1'b0, INT_DRIVER);
        idle(10);
        drive(1'b1, 1'b1, INT_ALARM_ON);
        idle(40);

        // 6: asynchronous reset mid-count, then a clean ARM countdown
        drive(1'b1, 1'b0, INT_PASSENGER);
        idle(10);
        @(posedge clock);
        #2;
        systemReset = 1'b1;
        #1;
        chk("async_busy", int'(tif.busy), 0);
        chk("async_remaining", int'(tif.remaining), 0);
        chk("async_interval", int'(tif.interval), 0);
        chk("async_expired", int'(tif.expired), 0);
        idle(2);
        systemReset = 1'b0;
        drive(1'b1, 1'b0, INT_ARM);
        idle(32);

        // Random traffic including parameter reprogramming
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            s = (r < 5) || (r == 9);
            a = (r == 5) || (r == 6) || (r == 9);
            if (r >= 10 && r <= 12) params[$urandom_range(0, 3)] = WIDTH'($urandom_range(0, 15));
            drive(s, a, 2'($urandom_range(0, 3)));
        end
        idle(70);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
